cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 flush  in  1  mispredict/squash; discards all held and pending results.
REQ-004 req_valid  in  SUPER  functional-unit result valid (index 0 mul, 1..ADD_NUM add, rest alu).
REQ-005 req_data  in  SUPER x word  functional-unit result data.
REQ-006 req_rs  in  SUPER x clog2(RS_SZ)  reservation-station slot of the producing instruction.
REQ-007 req_ready  out  SUPER  FU may present a result this cycle; equals !hold_valid[i].
REQ-008 mem_valid  in  1  memory load return valid; never back-pressured.
REQ-009 mem_data  in  word  memory load data.
REQ-010 mem_rs  in  clog2(RS_SZ)  reservation-station slot of the load.
REQ-011 cdb_valid  out  SUPER  broadcast slot valid, registered.
REQ-012 cdb_data  out  SUPER x word  broadcast data, registered.
REQ-013 cdb_rs  out  SUPER x clog2(RS_SZ)  broadcast RS index, registered.
REQ-014 cdb_is_mem  out  SUPER  slot carries the memory load, registered.

Function
REQ-015 Each FU i has one holding entry (hold_valid, hold_data, hold_rs); candidate i = held entry if hold_valid[i], else incoming request if req_valid[i] && req_ready[i].
REQ-016 req_valid[i] while req_ready[i]=0 is ignored, no state change.
REQ-017 mem_valid always wins slot 0, cdb_is_mem[0]=1 next cycle.
REQ-018 FU candidates scanned in rotating order starting at rr_ptr (rr_ptr, rr_ptr+1, ... mod SUPER), filling lowest free slots in ascending index.
REQ-019 Granted candidate appears on its slot one cycle later (latency 1); granted held entry clears hold_valid at the same edge.
REQ-020 Ungranted incoming candidate is captured into its holding entry; ungranted held entry is kept unchanged.
REQ-021 A held entry granted this cycle still shows req_ready=0 this cycle; new request accepted next cycle earliest.
REQ-022 rr_ptr advances to (last granted FU index + 1) mod SUPER when any FU is granted; else unchanged.
REQ-023 Unused slots drive cdb_valid=0; cdb_data/cdb_rs don't-care but held at 0.
REQ-024 flush: at next edge all hold_valid=0 and cdb_valid=0; same-cycle requests and mem_valid dropped; rr_ptr unchanged.
REQ-025 Same-cycle grant and capture on one FU impossible: captured entry only from ungranted incoming.
REQ-026 Starvation bound: any held entry granted within SUPER cycles while mem_valid absent at least every other cycle.

Reset
REQ-027 On rst assertion, immediately: hold_valid=0, rr_ptr=0, cdb_valid=0, cdb_data=0, cdb_rs=0, cdb_is_mem=0, req_ready all 1.
REQ-028 Reset mid-operation loses all held results; no broadcast on the first edge after deassertion unless new requests arrive that cycle.

Structure
REQ-029 Shared package holds SUPER, ADD_NUM, RS_SZ, word typedef, and cdb_entry_t struct {valid, data, rs, is_mem}.
REQ-030 One sub-module rr_select: rotating-priority multi-grant picker (SUPER request bits, start pointer, free-slot count in; grant vector and slot index per grant out), purely combinational.
REQ-031 Holding entries, rr_ptr and cdb output registers live in cdb_arbiter.

Verification (SUPER=3, ADD_NUM=1, RS_SZ=16)
REQ-032 Reset: assert rst mid-cycle -> all cdb_valid=0 immediately, req_ready=3'b111, rr_ptr=0.
REQ-033 FU0 req data 0x1234 rs 5, no mem -> next cycle cdb_valid=3'b001, cdb_data[0]=0x1234, cdb_rs[0]=5, cdb_is_mem=0.
REQ-034 mem_valid (0xAA, rs 2) plus all three FUs valid, rr_ptr=0 -> next cycle slot0 mem, slot1 FU0, slot2 FU1; FU2 held, req_ready=3'b011; rr_ptr=2; following cycle FU2 on slot0.
REQ-035 mem_valid and all FUs valid every cycle -> FU grant pairs (0,1),(2,0),(1,2) repeating; no held entry waits over 2 cycles.
REQ-036 FU1 and FU2 held, flush asserted with new FU0 request -> next cycle cdb_valid=0, req_ready=3'b111, FU0 result never broadcast.
REQ-037 Held FU2 granted same cycle req_valid[2]=1 -> new request ignored (req_ready[2]=0), accepted when re-presented next cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing, types and helpers for the common-data-bus arbiter.
package cdb_arbiter_pkg;

  localparam int SUPER   = 3;
  localparam int ADD_NUM = 1;
  localparam int RS_SZ   = 16;
  localparam int DATA_W  = 32;
  localparam int RS_W    = $clog2(RS_SZ);
  localparam int PTR_W   = (SUPER > 1) ? $clog2(SUPER) : 1;
  localparam int CNT_W   = $clog2(SUPER + 1);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [RS_W-1:0]   rs_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic  valid;
    word_t data;
    rs_t   rs;
    logic  is_mem;
  } cdb_entry_t;

  // Rotating increment of an FU index, wrapping at SUPER.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SUPER - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Rotating-priority multi-grant picker: scans requests from i_start and
// hands out the free CDB slots (the top i_free slots) in ascending order.
module cdb_arbiter_rr_select
  import cdb_arbiter_pkg::*;
(
  input  logic [SUPER-1:0] i_req,
  input  ptr_t             i_start,
  input  cnt_t             i_free,
  output logic [SUPER-1:0] o_grant,
  output ptr_t [SUPER-1:0] o_slot,
  output logic             o_any,
  output ptr_t             o_last
);

  cnt_t w_pos;
  ptr_t w_idx;

  // Walk FUs in rotated order, giving each requester the next free slot.
  always_comb begin
    o_grant = '0;
    o_slot  = '0;
    o_any   = 1'b0;
    o_last  = i_start;
    w_pos   = cnt_t'(SUPER) - i_free;
    w_idx   = '0;
    for (int k = 0; k < SUPER; k++) begin
      w_idx = ptr_t'((int'(i_start) + k) % SUPER);
      if (i_req[w_idx] && (int'(w_pos) < SUPER)) begin
        o_grant[w_idx] = 1'b1;
        o_slot[w_idx]  = ptr_t'(w_pos);
        w_pos          = w_pos + cnt_t'(1);
        o_any          = 1'b1;
        o_last         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: memory loads take slot 0 unconditionally; functional-unit
// results share the remaining slots by rotating priority, with one holding
// entry per FU for results that lose arbitration.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic [SUPER-1:0]  i_req_valid,
  input  word_t [SUPER-1:0] i_req_data,
  input  rs_t [SUPER-1:0]   i_req_rs,
  output logic [SUPER-1:0]  o_req_ready,
  input  logic              i_mem_valid,
  input  word_t             i_mem_data,
  input  rs_t               i_mem_rs,
  output logic [SUPER-1:0]  o_cdb_valid,
  output word_t [SUPER-1:0] o_cdb_data,
  output rs_t [SUPER-1:0]   o_cdb_rs,
  output logic [SUPER-1:0]  o_cdb_is_mem
);

  logic [SUPER-1:0]       r_hold_valid;
  word_t [SUPER-1:0]      r_hold_data;
  rs_t [SUPER-1:0]        r_hold_rs;
  ptr_t                   r_rr_ptr;
  cdb_entry_t [SUPER-1:0] r_cdb;

  logic [SUPER-1:0]       w_cand_valid;
  word_t [SUPER-1:0]      w_cand_data;
  rs_t [SUPER-1:0]        w_cand_rs;
  cnt_t                   w_free;
  logic [SUPER-1:0]       w_grant;
  ptr_t [SUPER-1:0]       w_slot;
  logic                   w_any;
  ptr_t                   w_last;
  cdb_entry_t [SUPER-1:0] w_next;

  // A held result takes precedence; requests arriving while held are ignored.
  always_comb begin
    o_req_ready  = ~r_hold_valid;
    w_cand_valid = r_hold_valid | i_req_valid;
    w_cand_data  = '0;
    w_cand_rs    = '0;
    for (int i = 0; i < SUPER; i++) begin
      w_cand_data[i] = r_hold_valid[i] ? r_hold_data[i] : i_req_data[i];
      w_cand_rs[i]   = r_hold_valid[i] ? r_hold_rs[i]   : i_req_rs[i];
    end
    w_free = i_mem_valid ? cnt_t'(SUPER - 1) : cnt_t'(SUPER);
  end

  cdb_arbiter_rr_select u_rr_select (
    .i_req   (w_cand_valid),
    .i_start (r_rr_ptr),
    .i_free  (w_free),
    .o_grant (w_grant),
    .o_slot  (w_slot),
    .o_any   (w_any),
    .o_last  (w_last)
  );

  // Assemble next-cycle broadcast: memory in slot 0, granted FUs after it.
  always_comb begin
    w_next = '0;
    if (i_mem_valid) begin
      w_next[0] = '{valid: 1'b1, data: i_mem_data, rs: i_mem_rs, is_mem: 1'b1};
    end
    for (int i = 0; i < SUPER; i++) begin
      if (w_grant[i]) begin
        w_next[w_slot[i]] = '{valid: 1'b1, data: w_cand_data[i], rs: w_cand_rs[i], is_mem: 1'b0};
      end
    end
  end

  // Control state and broadcast registers; flush squashes everything but rr_ptr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_valid <= '0;
      r_rr_ptr     <= '0;
      r_cdb        <= '0;
    end else if (i_flush) begin
      r_hold_valid <= '0;
      r_cdb        <= '0;
    end else begin
      r_hold_valid <= w_cand_valid & ~w_grant;
      r_cdb        <= w_next;
      if (w_any) begin
        r_rr_ptr <= ptr_inc(w_last);
      end
    end
  end

  // Capture payload of an incoming request that lost arbitration.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < SUPER; i++) begin
      if (!r_hold_valid[i] && i_req_valid[i] && !w_grant[i]) begin
        r_hold_data[i] <= i_req_data[i];
        r_hold_rs[i]   <= i_req_rs[i];
      end
    end
  end

  // Unpack registered broadcast entries onto the output ports.
  always_comb begin
    for (int i = 0; i < SUPER; i++) begin
      o_cdb_valid[i]  = r_cdb[i].valid;
      o_cdb_data[i]   = r_cdb[i].data;
      o_cdb_rs[i]     = r_cdb[i].rs;
      o_cdb_is_mem[i] = r_cdb[i].is_mem;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter (SUPER=3, ADD_NUM=1, RS_SZ=16).
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [SUPER-1:0]  req_valid;
  word_t [SUPER-1:0] req_data;
  rs_t [SUPER-1:0]   req_rs;
  logic [SUPER-1:0]  req_ready;
  logic              mem_valid;
  word_t             mem_data;
  rs_t               mem_rs;
  logic [SUPER-1:0]  cdb_valid;
  word_t [SUPER-1:0] cdb_data;
  rs_t [SUPER-1:0]   cdb_rs;
  logic [SUPER-1:0]  cdb_is_mem;

  int checks;
  int errors;

  cdb_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_rs     (req_rs),
    .o_req_ready  (req_ready),
    .i_mem_valid  (mem_valid),
    .i_mem_data   (mem_data),
    .i_mem_rs     (mem_rs),
    .o_cdb_valid  (cdb_valid),
    .o_cdb_data   (cdb_data),
    .o_cdb_rs     (cdb_rs),
    .o_cdb_is_mem (cdb_is_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_rs    = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    mem_rs    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mem 0xAA/rs2 plus all three FUs with distinct payloads
  task automatic drive_full();
    mem_valid   = 1'b1;
    mem_data    = 32'h0000_00AA;
    mem_rs      = 4'd2;
    req_valid   = 3'b111;
    req_data[0] = 32'h0000_0200; req_rs[0] = 4'd4;
    req_data[1] = 32'h0000_0201; req_rs[1] = 4'd5;
    req_data[2] = 32'h0000_0202; req_rs[2] = 4'd6;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL reset_init_valid got %b exp %b", cdb_valid, 3'b000); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_init_ready got %b exp %b", req_ready, 3'b111); end
    checks++; if (cdb_data !== '0 || cdb_rs !== '0 || cdb_is_mem !== 3'b000) begin errors++; $display("FAIL reset_init_payload got data %h rs %h mem %b exp zero", cdb_data, cdb_rs, cdb_is_mem); end
    @(negedge clk);
    rst = 1'b0;
    drive_full();
    tick();
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL reset_pre_ready got %b exp %b", req_ready, 3'b011); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL reset_mid_valid got %b exp %b", cdb_valid, 3'b000); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL reset_mid_ready got %b exp %b", req_ready, 3'b111); end
    checks++; if (dut.r_rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_mid_rrptr got %0d exp %0d", dut.r_rr_ptr, 0); end
    checks++; if (cdb_data !== '0 || cdb_rs !== '0 || cdb_is_mem !== 3'b000) begin errors++; $display("FAIL reset_mid_payload got data %h rs %h mem %b exp zero", cdb_data, cdb_rs, cdb_is_mem); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL reset_after_valid got %b exp %b", cdb_valid, 3'b000); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid   = 3'b001;
    req_data[0] = 32'h0000_1234;
    req_rs[0]   = 4'd5;
    tick();
    checks++; if (cdb_valid !== 3'b001) begin errors++; $display("FAIL single_valid got %b exp %b", cdb_valid, 3'b001); end
    checks++; if (cdb_data[0] !== 32'h0000_1234) begin errors++; $display("FAIL single_data got %h exp %h", cdb_data[0], 32'h0000_1234); end
    checks++; if (cdb_rs[0] !== 4'd5) begin errors++; $display("FAIL single_rs got %0d exp %0d", cdb_rs[0], 5); end
    checks++; if (cdb_is_mem !== 3'b000) begin errors++; $display("FAIL single_is_mem got %b exp %b", cdb_is_mem, 3'b000); end
    checks++; if (cdb_data[1] !== '0 || cdb_data[2] !== '0) begin errors++; $display("FAIL single_unused_data got %h %h exp 0", cdb_data[1], cdb_data[2]); end
    clear_inputs();
    tick();
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL single_idle_valid got %b exp %b", cdb_valid, 3'b000); end
  endtask

  task automatic test_mem_priority();
    do_reset();
    drive_full();
    tick();
    checks++; if (cdb_valid !== 3'b111) begin errors++; $display("FAIL mem_valid got %b exp %b", cdb_valid, 3'b111); end
    checks++; if (cdb_is_mem !== 3'b001) begin errors++; $display("FAIL mem_is_mem got %b exp %b", cdb_is_mem, 3'b001); end
    checks++; if (cdb_data[0] !== 32'hAA || cdb_rs[0] !== 4'd2) begin errors++; $display("FAIL mem_slot0 got %h/%0d exp %h/%0d", cdb_data[0], cdb_rs[0], 32'hAA, 2); end
    checks++; if (cdb_data[1] !== 32'h200 || cdb_rs[1] !== 4'd4) begin errors++; $display("FAIL mem_slot1 got %h/%0d exp %h/%0d", cdb_data[1], cdb_rs[1], 32'h200, 4); end
    checks++; if (cdb_data[2] !== 32'h201 || cdb_rs[2] !== 4'd5) begin errors++; $display("FAIL mem_slot2 got %h/%0d exp %h/%0d", cdb_data[2], cdb_rs[2], 32'h201, 5); end
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL mem_ready got %b exp %b", req_ready, 3'b011); end
    checks++; if (dut.r_rr_ptr !== 2'd2) begin errors++; $display("FAIL mem_rrptr got %0d exp %0d", dut.r_rr_ptr, 2); end
    clear_inputs();
    tick();
    checks++; if (cdb_valid !== 3'b001) begin errors++; $display("FAIL mem_held_valid got %b exp %b", cdb_valid, 3'b001); end
    checks++; if (cdb_data[0] !== 32'h202 || cdb_rs[0] !== 4'd6 || cdb_is_mem !== 3'b000) begin errors++; $display("FAIL mem_held_slot0 got %h/%0d/%b exp %h/%0d/%b", cdb_data[0], cdb_rs[0], cdb_is_mem, 32'h202, 6, 3'b000); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL mem_held_ready got %b exp %b", req_ready, 3'b111); end
  endtask

  task automatic test_rotation();
    int e1;
    int e2;
    do_reset();
    drive_full();
    for (int c = 0; c < 6; c++) begin
      tick();
      case (c % 3)
        0:       begin e1 = 0; e2 = 1; end
        1:       begin e1 = 2; e2 = 0; end
        default: begin e1 = 1; e2 = 2; end
      endcase
      checks++; if (cdb_valid !== 3'b111 || cdb_is_mem !== 3'b001) begin errors++; $display("FAIL rot_valid c%0d got %b/%b exp 111/001", c, cdb_valid, cdb_is_mem); end
      checks++; if (cdb_data[1] !== 32'h200 + 32'(e1)) begin errors++; $display("FAIL rot_slot1 c%0d got %h exp %h", c, cdb_data[1], 32'h200 + 32'(e1)); end
      checks++; if (cdb_data[2] !== 32'h200 + 32'(e2)) begin errors++; $display("FAIL rot_slot2 c%0d got %h exp %h", c, cdb_data[2], 32'h200 + 32'(e2)); end
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    drive_full();
    tick();
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL flush_pre_ready got %b exp %b", req_ready, 3'b011); end
    flush       = 1'b1;
    req_valid   = 3'b011;
    req_data[0] = 32'h0000_0500;
    req_rs[0]   = 4'd11;
    tick();
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL flush_valid got %b exp %b", cdb_valid, 3'b000); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL flush_ready got %b exp %b", req_ready, 3'b111); end
    checks++; if (dut.r_rr_ptr !== 2'd2) begin errors++; $display("FAIL flush_rrptr got %0d exp %0d", dut.r_rr_ptr, 2); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL flush_data got %h exp 0", cdb_data); end
    clear_inputs();
    tick();
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL flush_after_valid got %b exp %b", cdb_valid, 3'b000); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_full();
    req_data[2] = 32'h0000_0302;
    req_rs[2]   = 4'd9;
    tick();
    clear_inputs();
    req_valid   = 3'b100;
    req_data[2] = 32'h0000_03FF;
    req_rs[2]   = 4'd10;
    #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL b2b_ready_held got %b exp %b", req_ready, 3'b011); end
    tick();
    checks++; if (cdb_valid !== 3'b001) begin errors++; $display("FAIL b2b_held_valid got %b exp %b", cdb_valid, 3'b001); end
    checks++; if (cdb_data[0] !== 32'h302 || cdb_rs[0] !== 4'd9) begin errors++; $display("FAIL b2b_held_slot0 got %h/%0d exp %h/%0d", cdb_data[0], cdb_rs[0], 32'h302, 9); end
    checks++; if (req_ready !== 3'b111) begin errors++; $display("FAIL b2b_ready_free got %b exp %b", req_ready, 3'b111); end
    tick();
    checks++; if (cdb_valid !== 3'b001) begin errors++; $display("FAIL b2b_new_valid got %b exp %b", cdb_valid, 3'b001); end
    checks++; if (cdb_data[0] !== 32'h3FF || cdb_rs[0] !== 4'd10) begin errors++; $display("FAIL b2b_new_slot0 got %h/%0d exp %h/%0d", cdb_data[0], cdb_rs[0], 32'h3FF, 10); end
    clear_inputs();
    tick();
    checks++; if (cdb_valid !== 3'b000) begin errors++; $display("FAIL b2b_idle_valid got %b exp %b", cdb_valid, 3'b000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_mem_priority();
    test_rotation();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
